// File: rtl/cfg_dprio_status_sync_mc.sv
// cfg_dprio_status_sync_mc: round-robin multi-channel status snapshot delivered over a
// four-phase write_en/ack handshake into an asynchronous user domain, with optional timeout.
module cfg_dprio_status_sync_mc #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CH         = 4,
    parameter int CHG_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] stat_data_in,
    input  logic                         write_en_ack,
    output logic                         write_en,
    output logic [DATA_WIDTH-1:0]        stat_data_out,
    output logic [CH_W-1:0]              stat_ch_out,
    output logic                         timeout_err,
    output logic                         busy
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_N_ACK = 2'd2, BAD = 2'd3} state_t;

    state_t state, state_n;
    logic ack_m, ack_s;
    logic [NUM_CH*DATA_WIDTH-1:0] last_sent;
    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0] rr, sel, idx, ch_next;
    logic [CH_W:0] sum;
    logic [TW-1:0] cnt;
    logic any_pend, load, done, expire, exit_cond;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            pending[c] = (CHG_MODE == 0) ||
                (stat_data_in[c*DATA_WIDTH +: DATA_WIDTH] != last_sent[c*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Scan from the farthest offset back to rr so the nearest pending channel wins.
    always_comb begin
        any_pend = 1'b0;
        sel = '0;
        sum = '0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, rr} + (CH_W + 1)'(i);
            idx = CH_W'((sum >= NCH) ? sum - NCH : sum);
            if (pending[idx]) begin
                any_pend = 1'b1;
                sel = idx;
            end
        end
    end

    assign busy = (state == REQ) || (state == WAIT_N_ACK);
    assign ch_next = (stat_ch_out == CH_LAST) ? '0 : stat_ch_out + CH_W'(1);
    assign exit_cond = (state == REQ && ack_s) || (state == WAIT_N_ACK && !ack_s);
    assign expire = (TIMEOUT_CYCLES > 0) && busy && (cnt == T_LAST) && !exit_cond;
    assign load = (state == IDLE) && any_pend;
    assign done = (state == WAIT_N_ACK) && !ack_s;

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:       state_n = any_pend ? REQ : IDLE;
            REQ:        state_n = ack_s ? WAIT_N_ACK : REQ;
            WAIT_N_ACK: state_n = ack_s ? WAIT_N_ACK : IDLE;
            default:    state_n = IDLE;
        endcase
        if (expire)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_m         <= 1'b0;
            ack_s         <= 1'b0;
            write_en      <= 1'b0;
            timeout_err   <= 1'b0;
            stat_data_out <= '0;
            stat_ch_out   <= '0;
            rr            <= '0;
            cnt           <= '0;
            last_sent     <= '0;
        end else begin
            ack_m       <= write_en_ack;
            ack_s       <= ack_m;
            write_en    <= (state_n == REQ);
            timeout_err <= expire;
            cnt         <= load ? '0 : busy ? cnt + TW'(1) : cnt;
            if (load) begin
                stat_data_out <= stat_data_in[sel*DATA_WIDTH +: DATA_WIDTH];
                stat_ch_out   <= sel;
            end
            if (done || expire)
                rr <= ch_next;
            // An aborted handshake leaves last_sent alone so the channel stays pending.
            if (done)
                last_sent[stat_ch_out*DATA_WIDTH +: DATA_WIDTH] <= stat_data_out;
        end
    end
endmodule

// File: tb/tb_cfg_dprio_status_sync_mc.sv
// tb_cfg_dprio_status_sync_mc: scoreboard bench for a continuous-refresh instance and a
// change-detect instance with a 16-cycle handshake timeout.
module tb_cfg_dprio_status_sync_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] d0[4];
    logic [15:0] d1[4];
    logic [63:0] in0, in1;
    assign in0 = {d0[3], d0[2], d0[1], d0[0]};
    assign in1 = {d1[3], d1[2], d1[1], d1[0]};

    logic ack0 = 1'b0, ack1 = 1'b0;
    logic we0, we1, te0, te1, busy0, busy1;
    logic [15:0] do0, do1;
    logic [1:0] ch0, ch1;

    cfg_dprio_status_sync_mc #(.DATA_WIDTH(16), .NUM_CH(4), .CHG_MODE(0), .TIMEOUT_CYCLES(0)) u_cont (
        .clk(clk), .rst(rst), .stat_data_in(in0), .write_en_ack(ack0), .write_en(we0),
        .stat_data_out(do0), .stat_ch_out(ch0), .timeout_err(te0), .busy(busy0));

    cfg_dprio_status_sync_mc #(.DATA_WIDTH(16), .NUM_CH(4), .CHG_MODE(1), .TIMEOUT_CYCLES(16)) u_chg (
        .clk(clk), .rst(rst), .stat_data_in(in1), .write_en_ack(ack1), .write_en(we1),
        .stat_data_out(do1), .stat_ch_out(ch1), .timeout_err(te1), .busy(busy1));

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        bit          to;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur0, cur1;
    bit cur_ok;
    logic [15:0] m_last[4];
    logic [1:0] m_rr, rr0;
    bit ack_en1 = 1'b1;
    int to_seen, hi1;
    int checks, errors;
    logic prev_we0, prev_we1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model for the change-detect instance: next pending channel from the pointer.
    function automatic int find1();
        for (int i = 0; i < 4; i++)
            if (d1[m_rr + 2'(i)] != m_last[m_rr + 2'(i)])
                return int'(m_rr + 2'(i));
        return -1;
    endfunction

    // n_to deliveries that will time out (no last_sent update), then acked ones until quiet.
    function automatic void gen1(input int n_to);
        int kk;
        logic [1:0] k;
        for (int t = 0; t < n_to; t++) begin
            kk = find1();
            if (kk >= 0) begin
                k = 2'(kk);
                q1.push_back('{k, d1[k], 1'b1});
                m_rr = k + 2'd1;
            end
        end
        kk = find1();
        while (kk >= 0) begin
            k = 2'(kk);
            q1.push_back('{k, d1[k], 1'b0});
            m_last[k] = d1[k];
            m_rr = k + 2'd1;
            kk = find1();
        end
    endfunction

    task automatic wait_idle1(input string nm);
        for (int i = 0; i < 2000 && (q1.size() != 0 || busy1); i++)
            @(negedge clk);
        repeat (8) @(negedge clk);
        chk({nm, " busy"}, 32'(busy1), 32'd0);
        chk({nm, " drained"}, q1.size(), 32'd0);
    endtask

    task automatic wait_we1(input string nm, input logic lvl);
        for (int i = 0; i < 300 && we1 !== lvl; i++)
            @(negedge clk);
        chk(nm, 32'(we1), 32'(lvl));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ack0 = !rst && we0;
        ack1 = !rst && we1 && ack_en1;
    end

    // Monitor: pops the scoreboards on each write_en rise and checks the handshake end.
    initial begin
        prev_we0 = 1'b0;
        prev_we1 = 1'b0;
        cur_ok = 1'b0;
        rr0 = 2'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                rr0 = 2'd0;
                prev_we0 = 1'b0;
                prev_we1 = 1'b0;
                cur_ok = 1'b0;
            end else begin
                while (q0.size() < 4) begin
                    q0.push_back('{rr0, d0[rr0], 1'b0});
                    rr0 = rr0 + 2'd1;
                end
                if (we0 && !prev_we0) begin
                    cur0 = q0.pop_front();
                    chk("cont ch", 32'(ch0), 32'(cur0.ch));
                    chk("cont data", 32'(do0), 32'(cur0.data));
                end
                if (te0)
                    chk("cont timeout_err", 32'(te0), 32'd0);
                if (we1 && !prev_we1) begin
                    if (q1.size() == 0) begin
                        chk("chg unexpected delivery ch", 32'(ch1), 32'hffffffff);
                        cur_ok = 1'b0;
                    end else begin
                        cur1 = q1.pop_front();
                        cur_ok = 1'b1;
                        chk("chg ch", 32'(ch1), 32'(cur1.ch));
                        chk("chg data", 32'(do1), 32'(cur1.data));
                        chk("chg busy at rise", 32'(busy1), 32'd1);
                    end
                    hi1 = 0;
                end
                if (we1)
                    hi1++;
                if (!we1 && prev_we1 && cur_ok) begin
                    chk("chg data held", 32'(do1), 32'(cur1.data));
                    chk("chg ch held", 32'(ch1), 32'(cur1.ch));
                    chk("chg timeout_err", 32'(te1), 32'(cur1.to));
                    if (cur1.to) begin
                        chk("chg timeout length", hi1, 32'd16);
                        to_seen++;
                    end
                    cur_ok = 1'b0;
                end else if (te1) begin
                    chk("chg spurious timeout_err", 32'(te1), 32'd0);
                end
                prev_we0 = we0;
                prev_we1 = we1;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        to_seen = 0;
        d0 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        d1 = '{16'h0, 16'h0, 16'h0, 16'h0};
        m_last = '{16'h0, 16'h0, 16'h0, 16'h0};
        m_rr = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset cont outputs", 32'({we0, te0, busy0, do0, ch0}), 32'd0);
        chk("reset chg outputs", 32'({we1, te1, busy1, do1, ch1}), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("zero inputs idle", 32'(busy1), 32'd0);

        for (int c = 0; c < 4; c++)
            d1[c] = 16'($urandom_range(1, 65535));
        gen1(0);
        wait_idle1("all channels");

        d1[2] = 16'hA5A5;
        gen1(0);
        wait_idle1("ch2 only");

        d1[1] = d1[1] ^ 16'h00F0;
        gen1(0);
        wait_idle1("ch1 to rr2");

        d1[1] = d1[1] ^ 16'h0F00;
        d1[3] = d1[3] ^ 16'h0F00;
        gen1(0);
        wait_idle1("ch3 then ch1");

        ack_en1 = 1'b0;
        to_seen = 0;
        d1[1] = d1[1] ^ 16'h0001;
        d1[2] = d1[2] ^ 16'h0001;
        gen1(3);
        for (int i = 0; i < 600 && to_seen < 3; i++)
            @(negedge clk);
        chk("timeouts seen", to_seen, 32'd3);
        ack_en1 = 1'b1;
        wait_idle1("timeout retry");

        d1[0] = d1[0] ^ 16'h5A5A;
        gen1(0);
        wait_we1("mid change rise", 1'b1);
        d1[0] = d1[0] ^ 16'hFFFF;
        gen1(0);
        wait_idle1("mid change");

        repeat (6) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 1) == 1)
                    d1[c] = 16'($urandom);
            gen1(0);
            wait_idle1("random");
        end

        d1[3] = d1[3] ^ 16'h8000;
        gen1(0);
        wait_we1("pre-reset rise", 1'b1);
        wait_we1("pre-reset fall", 1'b0);
        rst = 1'b1;
        #1;
        chk("mid reset chg outputs", 32'({we1, te1, busy1, do1, ch1}), 32'd0);
        chk("mid reset cont outputs", 32'({we0, te0, busy0, do0, ch0}), 32'd0);
        q1.delete();
        m_last = '{16'h0, 16'h0, 16'h0, 16'h0};
        m_rr = 2'd0;
        if (d1[0] == 16'h0)
            d1[0] = 16'h0001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        gen1(0);
        wait_idle1("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
